// File: rtl/conv_layer_stream.sv
// conv_layer_stream: streaming K x K 2-D convolution over a raster-order pixel
// stream, producing OUT_CH signed, rescaled and saturated outputs per window.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   data_in        unsigned pixel, raster order, qualified by valid_in
//   valid_in       pixel qualifier, gaps allowed
//   w_we, w_data   weight/bias write strobe and signed value; the write is
//                  taken only while idle and advances a wrapping pointer
//   conv_out       channel c in bits [c*OUT_BITS +: OUT_BITS], signed
//   valid_out      one-cycle pulse per completed window
//   frame_done     high together with the last valid_out of a frame
//
// Build option: define CONV_RELU_EN to clamp negative results to 0 after
// saturation (fused ReLU). Left undefined, the signed result passes unchanged.

module conv_layer_stream #(
    parameter int unsigned WIDTH     = 28,
    parameter int unsigned HEIGHT    = 28,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned K         = 5,
    parameter int unsigned OUT_CH    = 3,
    parameter int unsigned W_BITS    = 8,
    parameter int unsigned OUT_BITS  = 12,
    parameter int unsigned FRAC      = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BITS-1:0]         data_in,
    input  logic                         valid_in,
    input  logic                         w_we,
    input  logic signed [W_BITS-1:0]     w_data,
    output logic [OUT_CH*OUT_BITS-1:0]   conv_out,
    output logic                         valid_out,
    output logic                         frame_done
);

    localparam int unsigned TAPS   = K * K;
    localparam int unsigned NW     = OUT_CH * (TAPS + 1);
    localparam int unsigned WP_W   = $clog2(NW);
    localparam int unsigned COL_W  = $clog2(WIDTH);
    localparam int unsigned ROW_W  = $clog2(HEIGHT);
    localparam int unsigned SR_LEN = (K - 1) * WIDTH + K;
    localparam int unsigned PROD_W = DATA_BITS + W_BITS + 1;
    localparam int unsigned ACC_W  = DATA_BITS + W_BITS + $clog2(TAPS) + 2;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
    localparam logic [WP_W-1:0]  WP_LAST   = WP_W'(NW - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_BITS - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_BITS - 1)));

    logic [COL_W-1:0]              col_q;
    logic [ROW_W-1:0]              row_q;
    logic [WP_W-1:0]               wptr_q;
    logic signed [W_BITS-1:0]      w_q [NW];
    logic [DATA_BITS-1:0]          sr_q [SR_LEN];
    logic signed [PROD_W-1:0]      prod_q [OUT_CH][TAPS];
    logic                          win_v_q, win_last_q;
    logic                          p1_v_q, p1_last_q;
    logic                          valid_q, done_q;
    logic [OUT_CH*OUT_BITS-1:0]    conv_q, conv_d;
    logic signed [ACC_W-1:0]       acc_c, shr_c, res_c;
    logic                          idle_c;

    // Weight writes only land when no frame is in progress and nothing is in flight.
    assign idle_c = (row_q == '0) && (col_q == '0) && !win_v_q && !p1_v_q && !valid_in;

    // Pixel history: sr_q[0] is the newest accepted pixel; K-1 full rows plus K pixels.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            sr_q[0] <= data_in;
            for (int i = 1; i < int'(SR_LEN); i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    // Stage 1: products. Tap r*K+c (top-left first) sits (K-1-r) rows and (K-1-c) pixels back.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < int'(OUT_CH); ch++) begin
            for (int r = 0; r < int'(K); r++) begin
                for (int c = 0; c < int'(K); c++) begin
                    prod_q[ch][r*K+c] <=
                        PROD_W'($signed({1'b0, sr_q[(K-1-r)*WIDTH + (K-1-c)]})) *
                        PROD_W'(w_q[ch*(TAPS+1) + r*K + c]);
                end
            end
        end
    end

    // Stage 2 combinational: bias-aligned sum, arithmetic rescale, saturation.
    always_comb begin
        conv_d = '0;
        acc_c  = '0;
        shr_c  = '0;
        res_c  = '0;
        for (int ch = 0; ch < int'(OUT_CH); ch++) begin
            acc_c = ACC_W'(w_q[ch*(TAPS+1) + TAPS]) <<< FRAC;
            for (int t = 0; t < int'(TAPS); t++) begin
                acc_c = acc_c + ACC_W'(prod_q[ch][t]);
            end
            shr_c = acc_c >>> FRAC;
            if (shr_c > SAT_MAX) begin
                res_c = SAT_MAX;
            end else if (shr_c < SAT_MIN) begin
                res_c = SAT_MIN;
            end else begin
                res_c = shr_c;
            end
`ifdef CONV_RELU_EN
            if (res_c[ACC_W-1]) begin
                res_c = '0;
            end
`else
`endif
            conv_d[ch*OUT_BITS +: OUT_BITS] = OUT_BITS'(res_c);
        end
    end

    // Raster counters, weight memory, valid/last pipeline and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            wptr_q     <= '0;
            win_v_q    <= 1'b0;
            win_last_q <= 1'b0;
            p1_v_q     <= 1'b0;
            p1_last_q  <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            conv_q     <= '0;
            for (int i = 0; i < int'(NW); i++) begin
                w_q[i] <= '0;
            end
        end else begin
            if (valid_in) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            win_v_q    <= valid_in && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
            win_last_q <= valid_in && (row_q == ROW_LAST) && (col_q == COL_LAST);
            p1_v_q     <= win_v_q;
            p1_last_q  <= win_last_q;
            valid_q    <= p1_v_q;
            done_q     <= p1_v_q && p1_last_q;
            if (p1_v_q) begin
                conv_q <= conv_d;
            end
            if (w_we && idle_c) begin
                w_q[wptr_q] <= w_data;
                wptr_q      <= (wptr_q == WP_LAST) ? '0 : wptr_q + WP_W'(1);
            end
        end
    end

    assign conv_out   = conv_q;
    assign valid_out  = valid_q;
    assign frame_done = done_q;

endmodule
